// File: rtl/shift_sub_divider.sv
// Restoring shift-subtract unsigned divider: DW-bit dividend by VW-bit divisor,
// one quotient bit per clock, start/busy/done handshake, divide-by-zero flag.
module shift_sub_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk_10kHz,
  input  logic          clr,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          div_zero
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t        state_r;
  logic [DW-1:0] d_r;
  logic [VW-1:0] v_r;
  logic [VW:0]   r_r;
  logic [CW-1:0] cnt_r;

  logic [VW:0]   t_s;
  logic [VW:0]   r_next_s;
  logic          ge_s;
  logic [DW-1:0] d_next_s;

  // One restoring step: shift the next dividend bit into R, subtract V when it fits
  always_comb begin
    t_s      = (r_r << 1) | (VW + 1)'(d_r[DW-1]);
    ge_s     = 1'b0;
    r_next_s = t_s;
    if (t_s >= {1'b0, v_r}) begin
      ge_s     = 1'b1;
      r_next_s = t_s - {1'b0, v_r};
    end else begin
      ge_s     = 1'b0;
      r_next_s = t_s;
    end
    d_next_s = {d_r[DW-2:0], ge_s};
  end

  // Sequencer: accept operands, iterate DW times, publish registered results
  always_ff @(posedge clk_10kHz or posedge clr) begin
    if (clr) begin
      state_r   <= IDLE;
      d_r       <= {DW{1'b0}};
      v_r       <= {VW{1'b0}};
      r_r       <= {(VW + 1){1'b0}};
      cnt_r     <= {CW{1'b0}};
      quotient  <= {DW{1'b0}};
      remainder <= {VW{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            if (divisor != {VW{1'b0}}) begin
              d_r      <= dividend;
              v_r      <= divisor;
              r_r      <= {(VW + 1){1'b0}};
              cnt_r    <= {CW{1'b0}};
              busy     <= 1'b1;
              done     <= 1'b0;
              div_zero <= 1'b0;
              state_r  <= CALC;
            end else begin
              // Divide by zero answers immediately with all-ones quotient
              quotient  <= {DW{1'b1}};
              remainder <= {VW{1'b0}};
              done      <= 1'b1;
              div_zero  <= 1'b1;
              state_r   <= IDLE;
            end
          end else begin
            done <= 1'b0;
          end
        end
        CALC: begin
          d_r   <= d_next_s;
          r_r   <= r_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            quotient  <= d_next_s;
            remainder <= r_next_s[VW-1:0];
            done      <= 1'b1;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            done <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed and swept checks of shift_sub_divider against an arithmetic reference model.
module tb_shift_sub_divider;

  logic        clk_10kHz = 1'b0;
  logic        clr       = 1'b1;
  logic        start     = 1'b0;
  logic [15:0] dividend  = 16'd0;
  logic [7:0]  divisor   = 8'd0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        busy, done, div_zero;

  int total = 0;
  int bad   = 0;

  shift_sub_divider #(.DW(16), .VW(8)) dut (
    .clk_10kHz (clk_10kHz),
    .clr       (clr),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk_10kHz = ~clk_10kHz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: result appears 16 edges after acceptance, computed with / and %
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [15:0] m_q = 16'd0, pend_q = 16'd0;
  logic [7:0]  m_r = 8'd0, pend_r = 8'd0;
  int          m_left = 0;

  always @(posedge clk_10kHz or posedge clr) begin
    if (clr) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_q = 16'd0; m_r = 8'd0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          if (divisor == 8'd0) begin
            m_done = 1'b1; m_dz = 1'b1; m_q = 16'hFFFF; m_r = 8'd0;
          end else begin
            m_busy = 1'b1; m_dz = 1'b0; m_left = 16;
            pend_q = dividend / divisor;
            pend_r = 8'(dividend % divisor);
          end
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_q = pend_q; m_r = pend_r;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk_10kHz) begin
    chk("m_busy", busy, m_busy);
    chk("m_done", done, m_done);
    chk("m_dz", div_zero, m_dz);
    chk("m_quot", quotient, m_q);
    chk("m_rem", remainder, m_r);
  end

  task automatic do_div(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk_10kHz);
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk_10kHz);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 0; bc = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      @(negedge clk_10kHz);
      lat++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL wait_done timeout act=%0d exp=done", lat);
    end
  endtask

  initial begin
    int lat, bc, seen;
    logic [15:0] a;
    logic [7:0]  b;

    // Reset state
    @(negedge clk_10kHz);
    chk("rst_quot", quotient, 0); chk("rst_rem", remainder, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_dz", div_zero, 0);
    clr = 1'b0;

    // 1: clr mid-CALC abandons the division
    do_div(16'd1000, 8'd7);
    repeat (7) @(negedge clk_10kHz);
    chk("t1_busy_before", busy, 1);
    #2 clr = 1'b1;
    #1;
    chk("t1_quot", quotient, 0); chk("t1_rem", remainder, 0);
    chk("t1_busy", busy, 0); chk("t1_done", done, 0); chk("t1_dz", div_zero, 0);
    @(negedge clk_10kHz);
    clr = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_10kHz);
      if (done) seen++;
    end
    chk("t1_no_done", seen, 0);

    // 2: 1000/7 latency and busy width
    do_div(16'd1000, 8'd7);
    wait_done(lat, bc);
    chk("t2_lat", lat, 16); chk("t2_busy_cycles", bc, 16);
    chk("t2_quot", quotient, 142); chk("t2_rem", remainder, 6); chk("t2_dz", div_zero, 0);
    @(negedge clk_10kHz);
    chk("t2_pulse", done, 0);

    // 3: max/max and divisor > dividend
    do_div(16'd65535, 8'd255);
    wait_done(lat, bc);
    chk("t3a_quot", quotient, 257); chk("t3a_rem", remainder, 0);
    do_div(16'd100, 8'd200);
    wait_done(lat, bc);
    chk("t3b_quot", quotient, 0); chk("t3b_rem", remainder, 100);

    // 4: divide by zero answers on the next edge
    do_div(16'd1234, 8'd0);
    chk("t4_done", done, 1); chk("t4_dz", div_zero, 1);
    chk("t4_quot", quotient, 16'hFFFF); chk("t4_rem", remainder, 0); chk("t4_busy", busy, 0);
    @(negedge clk_10kHz);
    chk("t4_done_fall", done, 0); chk("t4_dz_held", div_zero, 1);

    // 5: starts while busy are ignored
    do_div(16'd50000, 8'd3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_10kHz);
      start = 1'b1; dividend = 16'(k * 111 + 5); divisor = 8'(k + 1);
      @(negedge clk_10kHz);
      start = 1'b0;
    end
    wait_done(lat, bc);
    chk("t5_quot", quotient, 16666); chk("t5_rem", remainder, 2);

    // 6: start held high across the done cycle restarts back-to-back
    @(negedge clk_10kHz);
    dividend = 16'd100; divisor = 8'd7; start = 1'b1;
    @(negedge clk_10kHz);
    dividend = 16'd9; divisor = 8'd2;
    wait_done(lat, bc);
    chk("t6a_lat", lat, 16); chk("t6a_quot", quotient, 14); chk("t6a_rem", remainder, 2);
    @(negedge clk_10kHz);
    start = 1'b0;
    chk("t6_restart_busy", busy, 1); chk("t6_restart_done", done, 0);
    wait_done(lat, bc);
    chk("t6b_lat", lat, 16); chk("t6b_quot", quotient, 4); chk("t6b_rem", remainder, 1);

    // 7: sweep with corner operands mixed in
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 8'($urandom);
      case (i % 8)
        0: b = 8'd0;
        1: b = 8'd1;
        2: a = 16'hFFFF;
        3: b = 8'hFF;
        4: a = 16'd0;
        5: begin a = 16'hFFFF; b = 8'hFF; end
        default: ;
      endcase
      do_div(a, b);
      wait_done(lat, bc);
      if (b != 8'd0) begin
        chk("t7_ident", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
        chk("t7_rem_lt", (remainder < b) ? 32'd1 : 32'd0, 1);
      end else begin
        chk("t7_dz", div_zero, 1);
      end
    end

    repeat (2) @(negedge clk_10kHz);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
